// File: rtl/rca_seq_pkg.sv
// Shared constants for the nibble-serial ripple-carry adder sequencer.
package rca_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/rca_seq_ctrl_nibble_add.sv
// Combinational 4-bit ripple-carry slice shared by every nibble of a wide add.
module nibble_add
    import rca_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co
);

    assign {co, s4} = {1'b0, a4} + {1'b0, b4} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide adder built by iterating one nibble slice LSB-first with a registered carry.
// Optional subtract mode (a - b) is enabled by defining RCA_SEQ_SUB_EN.
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [4*NIBBLES-1:0]     a,
    input  logic [4*NIBBLES-1:0]     b,
    input  logic                     cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                     op_sub,
`endif
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [4*NIBBLES-1:0]     sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             c_q, c_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             start_ready_q, start_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
`ifdef RCA_SEQ_SUB_EN
    logic             op_sub_q, op_sub_d;
`endif

    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
    logic                slice_co;

    assign slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
`ifdef RCA_SEQ_SUB_EN
    // Subtraction is a + ~b + 1; the +1 comes from the carry seeded at accept.
    assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{op_sub_q}};
`else
    assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
`endif

    nibble_add u_slice (
        .a4 (slice_a),
        .b4 (slice_b),
        .ci (c_q),
        .s4 (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef RCA_SEQ_SUB_EN
        op_sub_d = op_sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_valid && start_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
`ifdef RCA_SEQ_SUB_EN
                    op_sub_d = op_sub;
                    if (op_sub) begin
                        c_d = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
                c_d   = slice_co;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    idx_d   = '0;
                    cout_d  = slice_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/status outputs are registered from the next state.
        start_ready_d = (state_d == ST_IDLE);
        res_valid_d   = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= 1'b0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
            start_ready_q <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
            op_sub_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            sum_q         <= sum_d;
            cout_q        <= cout_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
`ifdef RCA_SEQ_SUB_EN
            op_sub_q      <= op_sub_d;
`endif
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with NIBBLES=4; subtract cases run when RCA_SEQ_SUB_EN is defined.
module tb_rca_seq_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    logic         op_sub = 1'b0;
`endif
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    rca_seq_ctrl #(.NIBBLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef RCA_SEQ_SUB_EN
        .op_sub      (op_sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one op, wait for the result, optionally stall the consumer, then hand it off.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sub, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input bit scramble, input int hold);
        int lat;
        logic [W-1:0] held_sum;
        logic         held_cout;
        a = av;
        b = bv;
        cin = ci;
`ifdef RCA_SEQ_SUB_EN
        op_sub = sub;
`endif
        start_valid = 1'b1;
        chk({tag, ".ready_before"}, 32'(start_ready), 32'd1);
        step();
        start_valid = 1'b0;
        chk({tag, ".busy_run"}, 32'(busy), 32'd1);
        lat = 0;
        while (!res_valid && lat < 20) begin
            if (scramble) begin
                a = 16'hAAAA;
                b = 16'hAAAA;
`ifdef RCA_SEQ_SUB_EN
                op_sub = ~sub;
`endif
                cin = ~ci;
            end
            step();
            lat++;
        end
        chk({tag, ".latency_edges"}, 32'(lat), 32'(N));
        chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ".hold_valid"}, 32'(res_valid), 32'd1);
            chk({tag, ".hold_sum"}, 32'(sum), 32'(exp_sum));
            chk({tag, ".hold_cout"}, 32'(cout), 32'(held_cout));
            chk({tag, ".hold_ready"}, 32'(start_ready), 32'd0);
            chk({tag, ".hold_busy"}, 32'(busy), 32'd1);
            if (held_sum !== sum) held_sum = sum;
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, ".valid_after_hs"}, 32'(res_valid), 32'd0);
        chk({tag, ".ready_after_hs"}, 32'(start_ready), 32'd1);
        chk({tag, ".busy_after_hs"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen;

        // Reset state
        step();
        step();
        chk("rst.start_ready", 32'(start_ready), 32'd0);
        chk("rst.res_valid", 32'(res_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst.start_ready", 32'(start_ready), 32'd1);

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op("ripple_b1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("backpress", 16'hABCD, 16'h9876, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 3);
        run_op("isolation", 16'h8421, 16'h1357, 1'b0, 1'b0, 16'h9778, 1'b0, 1'b1, 0);

        // Reset during the second RUN cycle discards the op
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b0;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst.res_valid", 32'(res_valid), 32'd0);
        chk("midrst.sum", 32'(sum), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.cout", 32'(cout), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (res_valid) seen = 1'b1;
        end
        chk("midrst.no_result", 32'(seen), 32'd0);
        chk("midrst.ready", 32'(start_ready), 32'd1);
        run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

`ifdef RCA_SEQ_SUB_EN
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 0);
        run_op("add_after_sub", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
